data_bus_memory_responder: RTL and testbench

//  Responder (target) end of the core's data bus: accepts rd/wd requests from the bus

---
 rtl/data_bus_memory_responder_pkg.sv | 30 +++
 rtl/data_bus_memory_responder_if.sv | 25 ++
 rtl/data_bus_memory_responder_lane_align.sv | 39 +++
 rtl/data_bus_memory_responder.sv | 161 ++++++++++++++++
 tb/tb_data_bus_memory_responder.sv | 384 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_bus_memory_responder_pkg.sv
// data_bus_memory_responder_pkg: size codes, FSM encodings and lane masks
// shared by the data-bus responder and its lane aligner.
package data_bus_memory_responder_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_BAD  = 2'b11;

    localparam logic [1:0] ST_INIT   = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic [1:0]  lo;
        logic [31:0] wdata;
    } req_t;

    function automatic logic misaligned(logic [1:0] size, logic [1:0] lo);
        return (size == SIZE_HALF && lo[0]) ||
               (size == SIZE_WORD && lo != 2'b00);
    endfunction

endpackage

// File: rtl/data_bus_memory_responder_if.sv
// data_bus_memory_responder_if: rd/wd data-bus between initiator (master)
// and the memory responder (slave).
interface data_bus_memory_responder_if;

    logic        rd;
    logic        wd;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        ready;
    logic        busy;
    logic        err;

    modport master (
        output rd, wd, size, addr, data_in,
        input  data_out, ready, busy, err
    );

    modport slave (
        input  rd, wd, size, addr, data_in,
        output data_out, ready, busy, err
    );

endinterface

// File: rtl/data_bus_memory_responder_lane_align.sv
// data_bus_memory_responder_lane_align: size/offset -> byte enables,
// write-data replication and right-aligned, zero-extended read data.
module data_bus_memory_responder_lane_align
    import data_bus_memory_responder_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;

    assign shifted = rword_i >> {lo_i, 3'b000};

    always_comb begin
        be_o    = 4'b0000;
        wdata_o = wdata_i;
        rdata_o = rword_i;
        unique case (size_i)
            SIZE_BYTE: begin
                be_o    = BE_BYTE << lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {24'h0, shifted[7:0]};
            end
            SIZE_HALF: begin
                be_o    = BE_HALF << {lo_i[1], 1'b0};
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {16'h0, shifted[15:0]};
            end
            SIZE_WORD: be_o = BE_WORD;
            default:   be_o = 4'b0000;
        endcase
    end

endmodule

// File: rtl/data_bus_memory_responder.sv
// data_bus_memory_responder: data-bus target serving a word RAM with wait states.
// Define DBUS_RESP_ZERO_INIT_EN to clear the RAM word by word during INIT.
module data_bus_memory_responder
    import data_bus_memory_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_CYCLES = 1
) (
    input logic clk_i,
    input logic rst_i,
    data_bus_memory_responder_if.slave bus
);

    localparam int          IW        = $clog2(DEPTH);
    localparam logic [32:0] END_ADDR  = 33'(BASE_ADDR) + 33'(4 * DEPTH);
    localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES - 1);

    logic [1:0]    state_q, state_d;
    logic [3:0]    wait_q, wait_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic [31:0]   dout_q, dout_d;
    req_t          req_q, req_d;
    logic [IW-1:0] idx_q, idx_d;
`ifdef DBUS_RESP_ZERO_INIT_EN
    logic [IW-1:0] init_q, init_d;
`endif

    logic [31:0]   mem_q [DEPTH];

    logic          req_any, bad, done;
    logic [IW-1:0] req_idx;
    logic [3:0]    be;
    logic [31:0]   wdata, rdata;
    logic          mem_we;
    logic [IW-1:0] mem_idx;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;

    assign req_any = bus.rd | bus.wd;
    // Full 33-bit compare so the range check never wraps.
    assign bad = (bus.rd & bus.wd) ||
                 (bus.size == SIZE_BAD) ||
                 misaligned(bus.size, bus.addr[1:0]) ||
                 ({1'b0, bus.addr} < 33'(BASE_ADDR)) ||
                 ({1'b0, bus.addr} >= END_ADDR);
    assign req_idx = IW'((bus.addr - BASE_ADDR) >> 2);
    assign done    = (state_q == ST_ACCESS) && (wait_q == 4'd0);

    data_bus_memory_responder_lane_align u_align (
        .size_i  (req_q.size),
        .lo_i    (req_q.lo),
        .wdata_i (req_q.wdata),
        .rword_i (mem_q[idx_q]),
        .be_o    (be),
        .wdata_o (wdata),
        .rdata_o (rdata)
    );

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        busy_d  = busy_q;
        err_d   = 1'b0;
        dout_d  = dout_q;
        req_d   = req_q;
        idx_d   = idx_q;
`ifdef DBUS_RESP_ZERO_INIT_EN
        init_d  = init_q;
`endif
        unique case (state_q)
            ST_INIT: begin
`ifdef DBUS_RESP_ZERO_INIT_EN
                init_d = init_q + IW'(1);
                if (init_q == IW'(DEPTH - 1)) state_d = ST_IDLE;
`else
                state_d = ST_IDLE;
`endif
            end
            ST_IDLE: begin
                if (req_any && bad) begin
                    err_d = 1'b1;
                end else if (req_any) begin
                    state_d = ST_ACCESS;
                    busy_d  = 1'b1;
                    wait_d  = WAIT_LAST;
                    idx_d   = req_idx;
                    req_d   = '{write: bus.wd, size: bus.size,
                                lo: bus.addr[1:0], wdata: bus.data_in};
                end
            end
            ST_ACCESS: begin
                if (wait_q == 4'd0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    if (!req_q.write) dout_d = rdata;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_comb begin
        mem_we    = done & req_q.write;
        mem_idx   = idx_q;
        mem_be    = be;
        mem_wdata = wdata;
`ifdef DBUS_RESP_ZERO_INIT_EN
        if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_idx   = init_q;
            mem_be    = BE_WORD;
            mem_wdata = 32'h0;
        end
`endif
    end

    // Gating with rst_i drops a write whose final edge coincides with reset.
    always_ff @(posedge clk_i) begin
        if (mem_we && !rst_i) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) mem_q[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_INIT;
            wait_q  <= 4'd0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= 32'h0;
            req_q   <= '0;
            idx_q   <= '0;
`ifdef DBUS_RESP_ZERO_INIT_EN
            init_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
            req_q   <= req_d;
            idx_q   <= idx_d;
`ifdef DBUS_RESP_ZERO_INIT_EN
            init_q  <= init_d;
`endif
        end
    end

    assign bus.data_out = dout_q;
    assign bus.busy     = busy_q;
    assign bus.err      = err_q;
    assign bus.ready    = (state_q == ST_IDLE);

endmodule

// File: tb/tb_data_bus_memory_responder.sv
// tb_data_bus_memory_responder: directed and randomized checks of two responders
// (WAIT_CYCLES 1 and 3, DEPTH 16) against a byte-level memory model.
module tb_data_bus_memory_responder;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 16;
`ifdef DBUS_RESP_ZERO_INIT_EN
    localparam int INIT_CYC = DEPTH;
    localparam bit ZI       = 1'b1;
`else
    localparam int INIT_CYC = 1;
    localparam bit ZI       = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1, rst3, sel;
    logic        rd, wd;
    logic [1:0]  size;
    logic [31:0] addr, din;

    data_bus_memory_responder_if bus1 ();
    data_bus_memory_responder_if bus3 ();

    assign bus1.rd      = rd & ~sel;
    assign bus1.wd      = wd & ~sel;
    assign bus1.size    = size;
    assign bus1.addr    = addr;
    assign bus1.data_in = din;
    assign bus3.rd      = rd & sel;
    assign bus3.wd      = wd & sel;
    assign bus3.size    = size;
    assign bus3.addr    = addr;
    assign bus3.data_in = din;

    wire        o_busy  = sel ? bus3.busy     : bus1.busy;
    wire        o_err   = sel ? bus3.err      : bus1.err;
    wire        o_ready = sel ? bus3.ready    : bus1.ready;
    wire [31:0] o_dout  = sel ? bus3.data_out : bus1.data_out;

    data_bus_memory_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(1))
        dut1 (.clk_i(clk), .rst_i(rst1), .bus(bus1));
    data_bus_memory_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(3))
        dut3 (.clk_i(clk), .rst_i(rst3), .bus(bus3));

    int passed = 0;
    int total  = 0;
    logic [31:0] m1 [DEPTH];
    logic [31:0] m3 [DEPTH];
    logic [31:0] d1, d3;

    function automatic int wcyc();
        return sel ? 3 : 1;
    endfunction

    function automatic logic exp_err(logic r, logic w, logic [1:0] sz, logic [31:0] a);
        if (r && w) return 1'b1;
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1 && a % 2 != 0) return 1'b1;
        if (sz == 2'd2 && a % 4 != 0) return 1'b1;
        if (a < BASE || a >= BASE + 4 * DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] mread(logic [31:0] word, logic [31:0] a, logic [1:0] sz);
        logic [31:0] r;
        int n;
        n = 1 << sz;
        r = word >> (8 * int'(a % 4));
        if (n == 4) return r;
        return r & ((32'd1 << (8 * n)) - 32'd1);
    endfunction

    function automatic logic [31:0] mmerge(logic [31:0] word, logic [31:0] a,
                                           logic [1:0] sz, logic [31:0] d);
        int lane;
        for (int k = 0; k < (1 << sz); k++) begin
            lane = int'(a % 4) + k;
            word[8*lane +: 8] = d[8*k +: 8];
        end
        return word;
    endfunction

    function automatic logic [31:0] mget(int i);
        return sel ? m3[i] : m1[i];
    endfunction

    task automatic mset(int i, logic [31:0] v);
        if (sel) m3[i] = v;
        else m1[i] = v;
    endtask

    task automatic req(input logic r, input logic w, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d,
                       output int nb, output int bfirst, output int ne,
                       output int efirst, output logic [31:0] dout);
        @(negedge clk);
        rd = r; wd = w; size = sz; addr = a; din = d;
        @(negedge clk);
        rd = 1'b0; wd = 1'b0;
        nb = 0; ne = 0; bfirst = 0; efirst = 0;
        for (int c = 1; c <= 6; c++) begin
            if (o_busy) begin nb++; if (bfirst == 0) bfirst = c; end
            if (o_err)  begin ne++; if (efirst == 0) efirst = c; end
            @(negedge clk);
        end
        dout = o_dout;
    endtask

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (!o_ready && n < 40) begin @(negedge clk); n++; end
        total++;
        if (o_ready !== 1'b1) $display("FAIL %s: ready=%b want 1 after %0d cycles", nm, o_ready, n);
        else passed++;
    endtask

    task automatic test_reset();
        int r1, r3, n;
        sel = 1'b0; rd = 0; wd = 0; size = 0; addr = 0; din = 0;
        rst1 = 1'b1; rst3 = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({bus1.ready, bus1.busy, bus1.err} !== 3'b000)
            $display("FAIL reset_flags1: rdy/busy/err=%b want 000", {bus1.ready, bus1.busy, bus1.err});
        else passed++;
        total++;
        if (bus1.data_out !== 32'h0) $display("FAIL reset_dout1: got %h want 0", bus1.data_out);
        else passed++;
        total++;
        if ({bus3.ready, bus3.busy, bus3.err} !== 3'b000)
            $display("FAIL reset_flags3: rdy/busy/err=%b want 000", {bus3.ready, bus3.busy, bus3.err});
        else passed++;
        rst1 = 1'b0; rst3 = 1'b0;
        r1 = -1; r3 = -1; n = 0;
        while ((r1 < 0 || r3 < 0) && n < 40) begin
            @(negedge clk); n++;
            if (bus1.ready && r1 < 0) r1 = n;
            if (bus3.ready && r3 < 0) r3 = n;
        end
        total++;
        if (r1 != INIT_CYC) $display("FAIL ready_delay1: got %0d want %0d", r1, INIT_CYC);
        else passed++;
        total++;
        if (r3 != INIT_CYC) $display("FAIL ready_delay3: got %0d want %0d", r3, INIT_CYC);
        else passed++;
        d1 = 0; d3 = 0;
        for (int i = 0; i < DEPTH; i++) begin m1[i] = 0; m3[i] = 0; end
    endtask

    task automatic test_init_ignore();
        int nb, bf, ne, ef;
        logic [31:0] dv;
        sel = 1'b0;
        rst1 = 1'b1;
        repeat (2) @(negedge clk);
        rst1 = 1'b0;
        wd = 1'b1; size = 2'd2; addr = BASE; din = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        wd = 1'b0;
        wait_ready("init_ready");
        for (int i = 0; i < DEPTH; i++) m1[i] = 0;
        d1 = 0;
        req(1, 0, 2'd2, BASE, 0, nb, bf, ne, ef, dv);
        total++;
        if (dv !== 32'h0) $display("FAIL init_ignored: got %h want 0", dv);
        else passed++;
        req(1, 0, 2'd2, BASE + 60, 0, nb, bf, ne, ef, dv);
        total++;
        if (dv !== 32'h0) $display("FAIL init_zero_last: got %h want 0", dv);
        else passed++;
    endtask

    task automatic test_fill();
        int nb, bf, ne, ef, bad;
        logic [31:0] dv, d;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            bad = 0;
            for (int i = 0; i < DEPTH; i++) begin
                d = $urandom | 32'h1;
                req(0, 1, 2'd2, BASE + 4 * i, d, nb, bf, ne, ef, dv);
                if (nb != wcyc() || ne != 0) bad++;
                mset(i, d);
            end
            total++;
            if (bad != 0) $display("FAIL fill_w%0d: %0d bad writes want 0", wcyc(), bad);
            else passed++;
        end
    endtask

    task automatic test_basic();
        int nb, bf, ne, ef;
        logic [31:0] dv;
        sel = 1'b0;
        req(0, 1, 2'd2, BASE, 32'hDEAD_BEEF, nb, bf, ne, ef, dv);
        total++;
        if (nb != 1 || bf != 1) $display("FAIL wr_busy: cycles=%0d first=%0d want 1/1", nb, bf);
        else passed++;
        req(1, 0, 2'd2, BASE, 0, nb, bf, ne, ef, dv);
        total++;
        if (nb != 1 || bf != 1) $display("FAIL rd_busy: cycles=%0d first=%0d want 1/1", nb, bf);
        else passed++;
        total++;
        if (dv !== 32'hDEAD_BEEF) $display("FAIL rd_word: got %h want deadbeef", dv);
        else passed++;
        req(0, 1, 2'd2, BASE, 32'h1122_3344, nb, bf, ne, ef, dv);
        req(0, 1, 2'd0, BASE + 3, 32'h0000_00AA, nb, bf, ne, ef, dv);
        req(1, 0, 2'd2, BASE, 0, nb, bf, ne, ef, dv);
        total++;
        if (dv !== 32'hAA22_3344) $display("FAIL byte_merge: got %h want aa223344", dv);
        else passed++;
        req(1, 0, 2'd0, BASE + 2, 0, nb, bf, ne, ef, dv);
        total++;
        if (dv !== 32'h0000_0022) $display("FAIL byte_read: got %h want 00000022", dv);
        else passed++;
        req(1, 0, 2'd1, BASE + 2, 0, nb, bf, ne, ef, dv);
        total++;
        if (dv !== 32'h0000_AA22) $display("FAIL half_hi: got %h want 0000aa22", dv);
        else passed++;
        m1[0] = 32'hAA22_3344;
        d1 = dv;
    endtask

    task automatic test_errors();
        logic        er [6];
        logic        ew [6];
        logic [1:0]  es [6];
        logic [31:0] ea [6];
        int nb, bf, ne, ef;
        logic [31:0] dv;
        sel = 1'b0;
        er = '{1, 1, 1, 1, 1, 0};
        ew = '{0, 0, 0, 0, 1, 1};
        es = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd2, 2'd3};
        ea = '{BASE + 1, 32'h0FFC, BASE + 4 * DEPTH, BASE, BASE, BASE};
        for (int i = 0; i < 6; i++) begin
            req(er[i], ew[i], es[i], ea[i], 32'h5555_5555, nb, bf, ne, ef, dv);
            total++;
            if (ne != 1 || ef != 1 || nb != 0)
                $display("FAIL err_%0d: err=%0d@%0d busy=%0d want 1@1 busy 0", i, ne, ef, nb);
            else passed++;
            total++;
            if (dv !== d1) $display("FAIL err_dout_%0d: got %h want %h", i, dv, d1);
            else passed++;
        end
        req(1, 0, 2'd2, BASE, 0, nb, bf, ne, ef, dv);
        total++;
        if (dv !== m1[0]) $display("FAIL err_no_write: got %h want %h", dv, m1[0]);
        else passed++;
        d1 = dv;
    endtask

    task automatic test_back_to_back();
        logic ok;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            ok = 1'b1;
            @(negedge clk);
            rd = 1'b1; wd = 1'b0; size = 2'd2; addr = BASE + 4;
            for (int c = 0; c < wcyc(); c++) begin
                @(negedge clk);
                if (!o_busy) ok = 1'b0;
            end
            @(negedge clk);
            if (o_busy) ok = 1'b0;
            total++;
            if (o_dout !== mget(1)) $display("FAIL b2b_first_w%0d: got %h want %h", wcyc(), o_dout, mget(1));
            else passed++;
            addr = BASE + 8;
            @(negedge clk);
            total++;
            if (o_busy !== 1'b1) $display("FAIL b2b_accept_w%0d: busy=%b want 1", wcyc(), o_busy);
            else passed++;
            rd = 1'b0;
            for (int c = 1; c < wcyc(); c++) @(negedge clk);
            @(negedge clk);
            total++;
            if (o_dout !== mget(2) || o_busy !== 1'b0 || !ok)
                $display("FAIL b2b_second_w%0d: got %h busy=%b want %h busy 0", wcyc(), o_dout, o_busy, mget(2));
            else passed++;
            if (sel) d3 = o_dout;
            else d1 = o_dout;
        end
    endtask

    task automatic test_abort();
        int nb, bf, ne, ef;
        logic [31:0] dv;
        sel = 1'b1;
        @(negedge clk);
        rd = 1'b1; size = 2'd2; addr = BASE + 8;
        @(negedge clk);
        rd = 1'b0;
        @(negedge clk);
        rst3 = 1'b1;
        @(negedge clk);
        total++;
        if (o_busy !== 1'b0 || o_dout !== 32'h0)
            $display("FAIL abort_rd: busy=%b dout=%h want 0/0 (word %h)", o_busy, o_dout, m3[2]);
        else passed++;
        rst3 = 1'b0;
        wait_ready("abort_rd_ready");
        if (ZI) for (int i = 0; i < DEPTH; i++) m3[i] = 0;
        d3 = 0;
        @(negedge clk);
        wd = 1'b1; size = 2'd2; addr = BASE + 12; din = ~m3[3];
        @(negedge clk);
        wd = 1'b0;
        @(negedge clk);
        rst3 = 1'b1;
        @(negedge clk);
        total++;
        if (o_busy !== 1'b0) $display("FAIL abort_wr_busy: busy=%b want 0", o_busy);
        else passed++;
        rst3 = 1'b0;
        wait_ready("abort_wr_ready");
        if (ZI) for (int i = 0; i < DEPTH; i++) m3[i] = 0;
        req(1, 0, 2'd2, BASE + 12, 0, nb, bf, ne, ef, dv);
        total++;
        if (dv !== m3[3]) $display("FAIL abort_wr_ram: got %h want %h", dv, m3[3]);
        else passed++;
        d3 = dv;
    endtask

    task automatic test_random(input int s, input int n);
        int nb, bf, ne, ef, k, idx;
        logic r, w, e;
        logic [1:0] sz;
        logic [31:0] a, d, dv, prev;
        sel = s[0];
        for (int t = 0; t < n; t++) begin
            k = int'($urandom % 16);
            r = (k == 0) ? 1'b1 : k[0];
            w = (k == 0) ? 1'b1 : ~k[0];
            sz = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
            k = int'($urandom % 10);
            if (k == 0) a = BASE - 32'($urandom_range(1, 4));
            else if (k == 1) a = BASE + 4 * DEPTH + 32'($urandom % 8);
            else a = BASE + 32'($urandom % (4 * DEPTH));
            if ($urandom % 5 != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            d = $urandom;
            prev = sel ? d3 : d1;
            e = exp_err(r, w, sz, a);
            req(r, w, sz, a, d, nb, bf, ne, ef, dv);
            total++;
            if (e && (ne != 1 || nb != 0))
                $display("FAIL rnd_err a=%h sz=%0d r%0d w%0d: err=%0d busy=%0d want err", a, sz, r, w, ne, nb);
            else if (!e && (ne != 0 || nb != wcyc() || bf != 1))
                $display("FAIL rnd_busy a=%h sz=%0d: err=%0d busy=%0d@%0d want %0d@1", a, sz, ne, nb, bf, wcyc());
            else passed++;
            if (!e) idx = int'((a - BASE) / 4);
            if (!e && w) mset(idx, mmerge(mget(idx), a, sz, d));
            if (!e && r) prev = mread(mget(idx), a, sz);
            total++;
            if (dv !== prev) $display("FAIL rnd_dout a=%h sz=%0d r%0d: got %h want %h", a, sz, r, dv, prev);
            else passed++;
            if (sel) d3 = dv;
            else d1 = dv;
        end
    endtask

    initial begin
        test_reset();
`ifdef DBUS_RESP_ZERO_INIT_EN
        test_init_ignore();
`endif
        test_fill();
        test_basic();
        test_errors();
        test_back_to_back();
        test_abort();
        test_random(0, 60);
        test_random(1, 30);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
